// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode pipeline register: state encoding,
// exception codes and the legal instruction-memory window.
package fd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    HELD  = 2'd2
  } fd_state_e;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6FFC;

endpackage

// File: rtl/fd_exc_chk.sv
// Combinational fetch-address checker (misaligned or outside instruction memory -> AdEL).
// Only compiled when FD_FETCH_EXC_EN is defined, since only then does fd_reg use it.
`ifdef FD_FETCH_EXC_EN
module fd_exc_chk
  import fd_pkg::*;
(
  input  logic [31:0] pc,
  output logic [4:0]  exc_code
);

  always_comb begin
    exc_code = EXC_NONE;
    if ((pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI)) begin
      exc_code = EXC_ADEL;
    end
  end

endmodule
`endif

// File: rtl/fd_reg.sv
// F->D pipeline register with bubble/hold control, delay-slot tracking and a stall counter.
// Define FD_FETCH_EXC_EN to enable fetch-address exception checking on load.
module fd_reg
  import fd_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [31:0]      F_PC,
  input  logic [31:0]      F_PCplus8,
  input  logic [31:0]      F_Instr,
  input  logic             D_isBranch,
  output logic [31:0]      D_PC,
  output logic [31:0]      D_PCplus8,
  output logic [31:0]      D_Instr,
  output logic             D_valid,
  output logic             D_BD,
  output logic [4:0]       D_ExcCode,
  output logic [CNT_W-1:0] stall_cnt
);

  fd_state_e   state, state_next;
  logic        stall_inc;
  logic [31:0] load_instr;

`ifdef FD_FETCH_EXC_EN
  logic [4:0] f_exc;
  logic [4:0] exc_q;

  fd_exc_chk u_exc_chk (
    .pc      (F_PC),
    .exc_code(f_exc)
  );

  // A faulting fetch still records its PC but never forwards the fetched word.
  assign load_instr = (f_exc != EXC_NONE) ? 32'd0 : F_Instr;
  assign D_ExcCode  = exc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_q <= EXC_NONE;
    end else if (flush) begin
      exc_q <= EXC_NONE;
    end else if (en) begin
      exc_q <= f_exc;
    end
  end
`else
  assign load_instr = F_Instr;
  assign D_ExcCode  = EXC_NONE;
`endif

  assign D_valid   = (state != EMPTY);
  assign stall_inc = !flush && !en && (state != EMPTY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else if (en) begin
      state_next = VALID;
    end else if (state != EMPTY) begin
      state_next = HELD;
    end
  end

  // D_BD uses the pre-edge D_valid so a bubble can never mark its successor as a delay slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      D_PC      <= RESET_PC;
      D_PCplus8 <= RESET_PC + 32'd8;
      D_Instr   <= 32'd0;
      D_BD      <= 1'b0;
    end else if (flush) begin
      D_PC      <= RESET_PC;
      D_PCplus8 <= RESET_PC + 32'd8;
      D_Instr   <= 32'd0;
      D_BD      <= 1'b0;
    end else if (en) begin
      D_PC      <= F_PC;
      D_PCplus8 <= F_PCplus8;
      D_Instr   <= load_instr;
      D_BD      <= D_isBranch & D_valid;
    end
  end

  // Saturates at all-ones; deliberately survives flush so stalls accumulate across bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_inc && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fd_reg.sv
// Randomized self-checking bench for fd_reg against a behavioural model; a second
// instance with a 2-bit stall counter exercises saturation.
module tb_fd_reg;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] f_pc = 32'd0;
  logic [31:0] f_pc8 = 32'd8;
  logic [31:0] f_instr = 32'd0;
  logic        d_is_branch = 1'b0;

  logic [31:0] d_pc, d_pc8, d_instr;
  logic        d_valid, d_bd;
  logic [4:0]  d_exc;
  logic [15:0] stall_cnt;

  logic [31:0] s_pc, s_pc8, s_instr;
  logic        s_valid, s_bd;
  logic [4:0]  s_exc;
  logic [1:0]  s_stall;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model state.
  logic [31:0] m_pc, m_pc8, m_instr;
  logic        m_valid, m_bd;
  logic [4:0]  m_exc;
  int          m_stalls;

  always #5 clk = ~clk;

  fd_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .F_PC(f_pc), .F_PCplus8(f_pc8), .F_Instr(f_instr), .D_isBranch(d_is_branch),
    .D_PC(d_pc), .D_PCplus8(d_pc8), .D_Instr(d_instr), .D_valid(d_valid),
    .D_BD(d_bd), .D_ExcCode(d_exc), .stall_cnt(stall_cnt)
  );

  fd_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .F_PC(f_pc), .F_PCplus8(f_pc8), .F_Instr(f_instr), .D_isBranch(d_is_branch),
    .D_PC(s_pc), .D_PCplus8(s_pc8), .D_Instr(s_instr), .D_valid(s_valid),
    .D_BD(s_bd), .D_ExcCode(s_exc), .stall_cnt(s_stall)
  );

  function automatic logic [4:0] expected_exc(input logic [31:0] pc);
`ifdef FD_FETCH_EXC_EN
    if (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6FFC) return 5'd4;
`endif
    return 5'd0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc <= RST_PC; m_pc8 <= RST_PC + 32'd8; m_instr <= 32'd0;
      m_valid <= 1'b0; m_bd <= 1'b0; m_exc <= 5'd0; m_stalls <= 0;
    end else if (flush) begin
      m_pc <= RST_PC; m_pc8 <= RST_PC + 32'd8; m_instr <= 32'd0;
      m_valid <= 1'b0; m_bd <= 1'b0; m_exc <= 5'd0;
    end else if (!en) begin
      if (m_valid) m_stalls <= m_stalls + 1;
    end else begin
      m_pc <= f_pc; m_pc8 <= f_pc8; m_valid <= 1'b1;
      m_bd <= d_is_branch & m_valid;
      m_exc <= expected_exc(f_pc);
      m_instr <= (expected_exc(f_pc) != 5'd0) ? 32'd0 : f_instr;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareSet(input string tag, input logic [31:0] pc, input logic [31:0] pc8,
                            input logic [31:0] instr, input logic valid, input logic bd,
                            input logic [4:0] exc, input logic [31:0] stall, input int cap);
    checkOutput({tag, ".D_PC"}, pc, m_pc);
    checkOutput({tag, ".D_PCplus8"}, pc8, m_pc8);
    checkOutput({tag, ".D_Instr"}, instr, m_instr);
    checkOutput({tag, ".D_valid"}, 32'(valid), 32'(m_valid));
    checkOutput({tag, ".D_BD"}, 32'(bd), 32'(m_bd));
    checkOutput({tag, ".D_ExcCode"}, 32'(exc), 32'(m_exc));
    checkOutput({tag, ".stall_cnt"}, stall, 32'((m_stalls > cap) ? cap : m_stalls));
  endtask

  // Outputs change only on posedge or reset, so the falling edge is a stable sample point.
  always @(negedge clk) begin
    if (chk_en) begin
      compareSet("main", d_pc, d_pc8, d_instr, d_valid, d_bd, d_exc, 32'(stall_cnt), 65535);
      compareSet("sat", s_pc, s_pc8, s_instr, s_valid, s_bd, s_exc, 32'(s_stall), 3);
    end
  end

  // Drives one cycle of inputs just after a falling edge and returns after the next one.
  task automatic applyStimulus(input logic e, input logic fl, input logic br,
                               input logic [31:0] pc, input logic [31:0] instr);
    en = e; flush = fl; d_is_branch = br;
    f_pc = pc; f_pc8 = pc + 32'd8; f_instr = instr;
    @(negedge clk); #1;
  endtask

  logic [31:0] rpc;
  int          sel;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst.D_PC", d_pc, 32'h3000);
    checkOutput("rst.D_PCplus8", d_pc8, 32'h3008);
    checkOutput("rst.D_Instr", d_instr, 32'd0);
    checkOutput("rst.D_valid", 32'(d_valid), 32'd0);
    checkOutput("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk_en = 1'b1;
    reset = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h3000, 32'h3C01_1234);
    checkOutput("first.D_PC", d_pc, 32'h3000);
    checkOutput("first.D_PCplus8", d_pc8, 32'h3008);
    checkOutput("first.D_Instr", d_instr, 32'h3C01_1234);
    checkOutput("first.D_valid", 32'(d_valid), 32'd1);
    checkOutput("first.D_BD", 32'(d_bd), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h3004, 32'h1111_0000);
    checkOutput("slot.D_BD", 32'(d_bd), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h3008, 32'h2222_0000);
    checkOutput("after_slot.D_BD", 32'(d_bd), 32'd0);

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 32'h5000, 32'hDEAD_BEEF);
    checkOutput("hold.D_PC", d_pc, 32'h3008);
    checkOutput("hold.D_Instr", d_instr, 32'h2222_0000);
    checkOutput("hold.stall_cnt", 32'(stall_cnt), 32'd3);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h5000, 32'hDEAD_BEEF);
    checkOutput("flush.D_valid", 32'(d_valid), 32'd0);
    checkOutput("flush.D_Instr", d_instr, 32'd0);
    checkOutput("flush.D_PC", d_pc, 32'h3000);
    checkOutput("flush.stall_cnt", 32'(stall_cnt), 32'd3);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300C, 32'h3333_0000);
    checkOutput("bubble.D_BD", 32'(d_bd), 32'd0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h3010, 32'h0);
    checkOutput("sat.stall_cnt", 32'(s_stall), 32'd3);
    checkOutput("nosat.stall_cnt", 32'(stall_cnt), 32'd5);

`ifdef FD_FETCH_EXC_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h3002, 32'h4444_0000);
    checkOutput("mis.D_ExcCode", 32'(d_exc), 32'd4);
    checkOutput("mis.D_Instr", d_instr, 32'd0);
    checkOutput("mis.D_PC", d_pc, 32'h3002);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h7000, 32'h5555_0000);
    checkOutput("hi.D_ExcCode", 32'(d_exc), 32'd4);
    checkOutput("hi.D_Instr", d_instr, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h3004, 32'h6666_0000);
    checkOutput("ok.D_ExcCode", 32'(d_exc), 32'd0);
    checkOutput("ok.D_Instr", d_instr, 32'h6666_0000);
`endif

    // Reset asserted between edges during a stall must clear outputs immediately.
    en = 1'b0; flush = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checkOutput("async.D_valid", 32'(d_valid), 32'd0);
    checkOutput("async.D_PC", d_pc, 32'h3000);
    checkOutput("async.D_PCplus8", d_pc8, 32'h3008);
    checkOutput("async.stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("async.sat_stall", 32'(s_stall), 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: rpc = 32'h2FFC;
        1: rpc = 32'h6FFC;
        2: rpc = 32'h7000;
        3: rpc = $urandom;
        default: rpc = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
      endcase
      if ($urandom_range(0, 299) == 0) reset = 1'b0;
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 2) == 0), rpc, $urandom);
      reset = 1'b1;
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fd_reg.md
FD_REG -- requirements
Module: fd_reg

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, which is the D_PC and D_PCplus8 base after reset or flush.
REQ-002 SHALL have parameter CNT_W, default 16, which is the width of the stall-cycle counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserting it clears all state immediately.
REQ-005 en  input  1  1 = capture the F stage; 0 = stall and hold D.
REQ-006 flush  input  1  1 = load a bubble into D at the next edge.
REQ-007 F_PC  input  32  PC of the instruction being fetched.
REQ-008 F_PCplus8  input  32  F_PC+8, the link address.
REQ-009 F_Instr  input  32  instruction word from instruction memory.
REQ-010 D_isBranch  input  1  the current D instruction is a branch or jump, so the next captured instruction is its delay slot.
REQ-011 D_PC, D_PCplus8, D_Instr  output  32 each  registered F values.
REQ-012 D_valid  output  1  D holds a real instruction (not a bubble).
REQ-013 D_BD  output  1  the D instruction is in a branch delay slot.
REQ-014 D_ExcCode  output  5  fetch exception code; 0 = none.
REQ-015 stall_cnt  output  CNT_W  saturating count of cycles with en=0 while D_valid=1.

Function
REQ-016 Edge priority SHALL be: reset, then flush, then en=0 (hold), then en=1 (load).
REQ-017 Load SHALL do the following on the same edge: D_PC<=F_PC, D_PCplus8<=F_PCplus8, D_Instr<=F_Instr, D_valid<=1, D_BD<=D_isBranch&D_valid (value sampled before the edge); latency is 1 cycle.
REQ-018 Hold SHALL keep every D output unchanged, including D_BD and D_ExcCode.
REQ-019 Flush SHALL set D_Instr=0, D_valid=0, D_BD=0, D_ExcCode=0, D_PC=RESET_PC and D_PCplus8=RESET_PC+8; flush overrides en=0.
REQ-020 State machine SHALL use states EMPTY, VALID and HELD.
REQ-021 From EMPTY: load goes to VALID; hold stays in EMPTY.
REQ-022 From VALID: load stays in VALID; hold goes to HELD.
REQ-023 From HELD: load goes to VALID; hold stays in HELD.
REQ-024 From any state, flush or reset SHALL go to EMPTY.
REQ-025 D_valid SHALL be 1 exactly in VALID and HELD.
REQ-026 stall_cnt SHALL increment by 1 on each edge taken in HELD, or on VALID→HELD; it SHALL saturate at all-ones and never wrap; flush SHALL NOT clear it.
REQ-027 A bubble SHALL never set D_BD on the following load, because D_valid=0 masks D_isBranch.

Reset
REQ-028 While reset=0, outputs SHALL be: D_PC=RESET_PC, D_PCplus8=RESET_PC+8, D_Instr=0, D_valid=0, D_BD=0, D_ExcCode=0, stall_cnt=0, state EMPTY.
REQ-029 Reset asserted mid-stall SHALL clear all outputs without waiting for a clock edge.
REQ-030 The first edge after reset deasserts SHALL obey REQ-016.

Configuration
REQ-031 Macro FD_FETCH_EXC_EN, when defined, SHALL enable fetch-address checking on load.
REQ-032 With FD_FETCH_EXC_EN defined: if F_PC[1:0]!=0, or F_PC<32'h0000_3000, or F_PC>32'h0000_6FFC, then D_ExcCode<=4 (AdEL) and D_Instr<=0, while D_PC still captures F_PC.
REQ-033 With FD_FETCH_EXC_EN defined: a legal PC SHALL set D_ExcCode<=0.
REQ-034 Without FD_FETCH_EXC_EN: D_ExcCode SHALL be constant 0, F_Instr SHALL be passed unchanged, and no checker logic SHALL be instantiated.

Structure
REQ-035 Shared package fd_pkg SHALL hold: state encoding (EMPTY, VALID, HELD), EXC_ADEL=5'd4, EXC_NONE=5'd0, IMEM_LO=32'h0000_3000, IMEM_HI=32'h0000_6FFC.
REQ-036 Sub-module fd_exc_chk SHALL be combinational (F_PC → exc code) and instantiated only under FD_FETCH_EXC_EN.

Verification
REQ-037 Reset deassert then en=1 with F_PC=0x3000, F_Instr=0x3C01_1234 → next cycle D_PC=0x3000, D_PCplus8=0x3008, D_Instr=0x3C01_1234, D_valid=1, D_BD=0.
REQ-038 Valid D with D_isBranch=1, then load with F_PC=0x3004 → D_BD=1; a following load with D_isBranch=0 → D_BD=0.
REQ-039 en=0 for 3 cycles with D_valid=1 → D outputs unchanged and stall_cnt=3; en=0 with flush=1 → D_valid=0, D_Instr=0, D_PC=0x3000.
REQ-040 With FD_FETCH_EXC_EN defined: F_PC=0x3002, then F_PC=0x7000 → D_ExcCode=4 and D_Instr=0 each time; F_PC=0x3004 → D_ExcCode=0.
REQ-041 Reset pulled low mid-stall between edges → outputs reach reset values before the next edge; with CNT_W=2, 5 HELD cycles → stall_cnt=3 (saturated).
